// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one column at a time, samples the synchronized
// row lines, debounces whole-frame results and queues accepted key codes.
module keypad_scanner #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 65536,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4,
    localparam int CW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ROWS-1:0] fila,
    output logic [COLS-1:0] col,
    input  logic            key_rd,
    input  logic            ovf_clr,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_held,
    output logic            ovf
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int NW = $clog2(DEBOUNCE + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, PRESSED} state_t;

    logic [ROWS-1:0] fila_s1_reg, fila_s2_reg;
    logic [DW-1:0]   div_reg;
    logic [IW-1:0]   col_reg;
    logic            tick, last_col, frame_eval;

    logic            col_hit;
    logic [CW-1:0]   col_code;
    logic            merged_hit;
    logic [CW-1:0]   merged_code;
    logic            acc_hit_reg;
    logic [CW-1:0]   acc_code_reg;

    logic            cand_hit_reg, cand_hit_next;
    logic [CW-1:0]   cand_code_reg, cand_code_next;
    logic [NW-1:0]   cnt_reg, cnt_next;
    logic            stable;

    state_t          state_reg, state_next;
    logic [CW-1:0]   pressed_code_reg, pressed_code_next;
    logic            push;

    logic [CW-1:0]   mem_reg [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic            pop, full, do_write, drop;
    logic            ovf_reg;

    // Two-flop synchronizer for the asynchronous row lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fila_s1_reg <= '0;
            fila_s2_reg <= '0;
        end else begin
            fila_s1_reg <= fila;
            fila_s2_reg <= fila_s1_reg;
        end
    end

    assign tick       = (div_reg == DW'(SCAN_DIV - 1));
    assign last_col   = (col_reg == IW'(COLS - 1));
    assign frame_eval = tick && last_col;

    // Scan divider and column index; a column steps on every tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg <= '0;
            col_reg <= '0;
        end else begin
            div_reg <= tick ? '0 : div_reg + DW'(1);
            if (tick) begin
                col_reg <= last_col ? '0 : col_reg + IW'(1);
            end
        end
    end

    // One-hot column drive decoded from the column index
    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        assign col[gi] = (col_reg == IW'(gi));
    end

    // Lowest active row of the current column, merged with the frame so far (lowest code wins)
    always_comb begin
        col_hit  = 1'b0;
        col_code = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (fila_s2_reg[r]) begin
                col_hit  = 1'b1;
                col_code = CW'(r * COLS) + CW'(col_reg);
            end
        end
        merged_hit = acc_hit_reg || col_hit;
        if (col_hit && (!acc_hit_reg || col_code < acc_code_reg)) begin
            merged_code = col_code;
        end else begin
            merged_code = acc_code_reg;
        end
    end

    // Frame accumulator, cleared when the frame result is handed to the debouncer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hit_reg  <= 1'b0;
            acc_code_reg <= '0;
        end else if (tick) begin
            if (last_col) begin
                acc_hit_reg  <= 1'b0;
                acc_code_reg <= '0;
            end else begin
                acc_hit_reg  <= merged_hit;
                acc_code_reg <= merged_code;
            end
        end
    end

    // Candidate tracking: repeat of the same frame result extends the stable run
    always_comb begin
        cand_hit_next  = cand_hit_reg;
        cand_code_next = cand_code_reg;
        cnt_next       = cnt_reg;
        if (frame_eval) begin
            if (merged_hit == cand_hit_reg && merged_code == cand_code_reg) begin
                if (cnt_reg != NW'(DEBOUNCE)) begin
                    cnt_next = cnt_reg + NW'(1);
                end
            end else begin
                cand_hit_next  = merged_hit;
                cand_code_next = merged_code;
                cnt_next       = NW'(1);
            end
        end
        stable = frame_eval && (cnt_next == NW'(DEBOUNCE));
    end

    // Candidate register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_hit_reg  <= 1'b0;
            cand_code_reg <= '0;
            cnt_reg       <= '0;
        end else begin
            cand_hit_reg  <= cand_hit_next;
            cand_code_reg <= cand_code_next;
            cnt_reg       <= cnt_next;
        end
    end

    // Debounce FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            pressed_code_reg <= '0;
        end else begin
            state_reg        <= state_next;
            pressed_code_reg <= pressed_code_next;
        end
    end

    // Debounce FSM: push once per newly accepted code, never for a held key
    always_comb begin
        state_next        = state_reg;
        pressed_code_next = pressed_code_reg;
        push              = 1'b0;
        case (state_reg)
            IDLE: begin
                if (stable && cand_hit_next) begin
                    state_next        = PRESSED;
                    pressed_code_next = cand_code_next;
                    push              = 1'b1;
                end
            end
            PRESSED: begin
                if (stable) begin
                    if (!cand_hit_next) begin
                        state_next = IDLE;
                    end else if (cand_code_next != pressed_code_reg) begin
                        pressed_code_next = cand_code_next;
                        push              = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign key_held  = (state_reg == PRESSED);
    assign key_valid = (count_reg != '0);
    assign full      = (count_reg == (AW + 1)'(FIFO_DEPTH));
    assign pop       = key_rd && key_valid;
    assign do_write  = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign key_code  = key_valid ? mem_reg[rd_ptr_reg] : '0;
    assign ovf       = ovf_reg;

    // FIFO storage; contents are only visible through key_valid so no reset is needed
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_reg[wr_ptr_reg] <= cand_code_next;
        end
    end

    // FIFO pointers, occupancy and sticky overflow (a drop beats a clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_write, pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (drop) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model feeds the rows from the
// pressed-key set; a frame-level reference model predicts the outputs.
module tb_keypad_scanner;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int SD    = 4;
    localparam int DEB   = 2;
    localparam int DEPTH = 2;
    localparam int NK    = ROWS * COLS;
    localparam int FRAME = SD * COLS;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [ROWS-1:0] fila;
    logic [COLS-1:0] col;
    logic            key_rd = 1'b0;
    logic            ovf_clr = 1'b0;
    logic [3:0]      key_code;
    logic            key_valid, key_held, ovf;
    logic [NK-1:0]   keys = '0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_q[$];
    bit m_ovf;
    int m_prev;
    int m_run;
    bit m_held;
    int m_held_code;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fila(fila), .col(col), .key_rd(key_rd),
        .ovf_clr(ovf_clr), .key_code(key_code), .key_valid(key_valid),
        .key_held(key_held), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its driven column
    always_comb begin
        fila = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (keys[r*COLS+c] && col[c]) fila[r] = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf = 0; m_prev = -1; m_run = 0; m_held = 0; m_held_code = 0;
    endtask

    // One frame of the key set: the lowest pressed key index is the frame code
    task automatic model_frame(input logic [NK-1:0] k, output bit acc, output int code);
        int r;
        r = -1;
        for (int i = NK - 1; i >= 0; i--) if (k[i]) r = i;
        if (r == m_prev) m_run++;
        else begin m_prev = r; m_run = 1; end
        acc = 0; code = 0;
        if (m_run == DEB) begin
            if (r >= 0 && (!m_held || r != m_held_code)) begin
                acc = 1; code = r; m_held = 1; m_held_code = r;
            end else if (r < 0) begin
                m_held = 0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(key_valid), 32'(m_q.size() > 0));
        check({tag, ".code"}, 32'(key_code), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
        check({tag, ".held"}, 32'(key_held), 32'(m_held));
        check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    endtask

    // One full frame with key set k; key_rd / ovf_clr pulsed on the given edge (0 = none)
    task automatic run_frame(input string tag, input logic [NK-1:0] k, input int rd_at, input int clr_at);
        bit acc;
        int code;
        keys = k;
        for (int cyc = 1; cyc <= FRAME; cyc++) begin
            key_rd  = (cyc == rd_at);
            ovf_clr = (cyc == clr_at);
            @(posedge clk);
            if (key_rd && m_q.size() > 0) void'(m_q.pop_front());
            if (ovf_clr) m_ovf = 0;
            if (cyc == FRAME) begin
                model_frame(k, acc, code);
                if (acc) begin
                    if (m_q.size() < DEPTH) m_q.push_back(code);
                    else m_ovf = 1;
                end
            end
            #1;
            if (cyc % SD == 0) check({tag, ".col"}, 32'(col), 32'(1) << ((cyc / SD) % COLS));
        end
        key_rd = 0;
        ovf_clr = 0;
        check_outputs(tag);
        $display("frame %-8s keys=%04h valid=%0b code=%0d held=%0b ovf=%0b", tag, k, key_valid, key_code, key_held, ovf);
    endtask

    // Reset pulse starting just after a rising edge; released just after the next one
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".col"}, 32'(col), 32'd1);
        check_outputs(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("reset %s", tag);
    endtask

    initial begin
        logic [NK-1:0] k;
        int rd, clr;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        do_reset("rst0");

        // Single key row1/col2 -> code 6 after two frames, pushed once
        run_frame("p6a", 16'h0040, 0, 0);
        check("p6a.nopush", 32'(key_valid), 32'd0);
        run_frame("p6b", 16'h0040, 0, 0);
        check("p6b.code6", 32'(key_code), 32'd6);
        run_frame("p6c", 16'h0040, 0, 0);
        run_frame("rel1", 16'h0000, 0, 0);
        run_frame("rel2", 16'h0000, 5, 0);
        check("rel2.held", 32'(key_held), 32'd0);

        // Bounce: key toggles every other frame
        for (int i = 0; i < 6; i++) run_frame("bounce", (i % 2 == 0) ? 16'h0020 : 16'h0000, 0, 0);
        check("bounce.held", 32'(key_held), 32'd0);

        // Two rows on column 3 -> lowest row wins (code 3)
        run_frame("c3a", 16'h0808, 0, 0);
        run_frame("c3b", 16'h0808, 0, 0);
        check("c3b.code3", 32'(key_code), 32'd3);
        run_frame("c3r1", 16'h0000, 3, 0);
        run_frame("c3r2", 16'h0000, 0, 0);
        check("c3r2.held", 32'(key_held), 32'd0);

        // Overflow: three accepts into a depth-2 FIFO
        for (int i = 1; i <= 3; i++) begin
            run_frame("ovfa", 16'(1) << i, 0, 0);
            run_frame("ovfb", 16'(1) << i, 0, 0);
        end
        check("ovf.set", 32'(ovf), 32'd1);
        run_frame("ovfclr", 16'h0000, 0, 4);
        check("ovf.clr", 32'(ovf), 32'd0);
        run_frame("idle", 16'h0000, 0, 0);

        // Full FIFO: read coinciding with an accept
        run_frame("rdacc1", 16'h0010, 0, 0);
        run_frame("rdacc2", 16'h0010, FRAME, 0);
        check("rdacc.head", 32'(key_code), 32'd2);
        check("rdacc.ovf", 32'(ovf), 32'd0);

        // Full FIFO: drop and clear on the same edge -> overflow stays set
        run_frame("setclr1", 16'h0020, 0, 0);
        run_frame("setclr2", 16'h0020, 0, FRAME);
        check("setclr.ovf", 32'(ovf), 32'd1);

        // Reset in the middle of a debounce run
        run_frame("md1", 16'h0080, 0, 0);
        keys = 16'h0080;
        repeat (7) @(posedge clk);
        #1;
        keys = 16'h0000;
        do_reset("rstmid");
        run_frame("md2", 16'h0000, 0, 0);
        run_frame("md3", 16'h0000, 0, 0);
        check("md.nopush", 32'(key_valid), 32'd0);

        // Randomized frames with random reads and clears
        k = '0;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(99) < 45) begin
                case ($urandom_range(3))
                    0: k = '0;
                    1, 2: k = 16'(1) << $urandom_range(NK - 1);
                    default: k = (16'(1) << $urandom_range(NK - 1)) | (16'(1) << $urandom_range(NK - 1));
                endcase
            end
            rd  = ($urandom_range(99) < 35) ? int'($urandom_range(FRAME, 1)) : 0;
            clr = ($urandom_range(99) < 10) ? int'($urandom_range(FRAME, 1)) : 0;
            run_frame("rand", k, rd, clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter ROWS, default 4, number of keypad rows (fila inputs), 1..8.
REQ-002 Parameter COLS, default 4, number of keypad columns (col outputs), 1..8.
REQ-003 Parameter SCAN_DIV, default 65536, clk cycles per column step, >=2.
REQ-004 Parameter DEBOUNCE, default 3, consecutive identical scan frames required to accept a press or release, >=1.
REQ-005 Parameter FIFO_DEPTH, default 4, key-code buffer entries, power of two >=2.
REQ-006 Localparam CW = clog2(ROWS*COLS), minimum 1, key-code width.
REQ-007 clk  input  1  single system clock, all state on rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 fila  input  ROWS  row sense lines, active-high, asynchronous to clk.
REQ-010 col  output  COLS  one-hot column drive.
REQ-011 key_rd  input  1  pops the FIFO head when key_valid=1.
REQ-012 ovf_clr  input  1  clears ovf.
REQ-013 key_code  output  CW  FIFO head code; 0 when empty.
REQ-014 key_valid  output  1  FIFO not empty.
REQ-015 key_held  output  1  a debounced key is currently pressed.
REQ-016 ovf  output  1  sticky flag, a code was dropped because the FIFO was full.

Function
REQ-017 fila SHALL pass through a 2-flop synchronizer before any use.
REQ-018 A divider SHALL assert a one-cycle tick every SCAN_DIV clk cycles; the first tick occurs SCAN_DIV cycles after reset release.
REQ-019 On each tick, the block SHALL sample synchronized fila for the currently driven column, then advance the column index c (wrap COLS-1 -> 0); col = 1<<c at all times.
REQ-020 Code for row r, column c SHALL be r*COLS+c; within a column the lowest active row wins; within a frame the lowest code wins.
REQ-021 A frame SHALL be COLS consecutive samples from c=0 through c=COLS-1; the frame result (hit, code) is evaluated on the tick that samples c=COLS-1.
REQ-022 The debouncer SHALL hold a candidate (hit, code) and a stable counter: a frame result equal to the candidate increments the counter (saturating at DEBOUNCE); a differing result loads the new candidate with the counter set to 1.
REQ-023 Debouncer states: IDLE, PRESSED. IDLE -> PRESSED when the candidate is a hit and its counter reaches DEBOUNCE; the code is pushed exactly once on that transition.
REQ-024 In PRESSED, a different hit code stable for DEBOUNCE frames SHALL push the new code and remain in PRESSED; no hit stable for DEBOUNCE frames SHALL return to IDLE; a held key never re-pushes.
REQ-025 key_held = (state == PRESSED).
REQ-026 FIFO: push on accept, pop on key_rd && key_valid; key_rd when empty is ignored.
REQ-027 Push with pop in the same cycle while full SHALL complete both, with no overflow.
REQ-028 Push while full without pop SHALL drop the code and set ovf; ovf clears only on ovf_clr or reset; if set and clear coincide, set wins.
REQ-029 Accept-to-key_valid latency SHALL be one clk cycle after the frame-evaluation tick.

Reset
REQ-030 While rst_n=0: col = 1 (c=0), divider=0, synchronizers=0, state IDLE, candidate no-hit with counter 0, FIFO empty, key_code=0, key_valid=0, key_held=0, ovf=0.
REQ-031 Reset asserted mid-frame or mid-debounce SHALL abort immediately; the first frame after release starts at c=0.

Verification
REQ-032 SCAN_DIV=4, DEBOUNCE=2: hold row1/col2 (4x4) -> code 6 pushed once after 2 full frames; key_held=1; key_valid=1 with key_code=6.
REQ-033 Bounce: toggle the key every other frame -> no push, key_held stays 0.
REQ-034 Press rows 0 and 2 on column 3 together -> code 3 accepted; release for 2 frames -> key_held=0.
REQ-035 FIFO_DEPTH=2, accept 3 presses without key_rd -> codes 1 and 2 held, third dropped, ovf=1; ovf_clr -> ovf=0.
REQ-036 Full FIFO, key_rd coinciding with an accept -> head popped, new code appended, ovf stays 0.
REQ-037 rst_n low mid-debounce for 1 cycle -> all outputs at reset values, col=0001, no push from the interrupted press.
